data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the CPU data-memory request/response interface.
- Services the load/store requests the CPU control path issues: MemRead, MemWrite, Write_strb, Address, Write_data.
- Contains a word-organised RAM and enforces a configurable access latency through a valid/ready handshake.
- Sits between the CPU core and the simulation top; also acts as the reference memory model in CPU benches.

Parameters:
ADDR_W, 10, word-index width; RAM depth = 2^ADDR_W 32-bit words
LATENCY, 2, wait cycles between request acceptance and completion (0..15)
LFSR_SEED, 16'hACE1, seed of the stall LFSR (used only with the optional feature)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-low reset
Address  in  32  byte address; word index = Address[ADDR_W+1:2]; bits [1:0] and bits above ADDR_W+1 ignored
MemWrite  in  1  write request
MemRead  in  1  read request
Write_data  in  32  store data
Write_strb  in  4  byte enables; bit i enables byte lane [8i+7:8i]
Mem_Req_Ready  out  1  responder can accept a request this cycle
Read_data  out  32  load data, held stable while Read_data_Valid=1
Read_data_Valid  out  1  load data valid
Read_data_Ready  in  1  CPU accepts load data

Behaviour:
- Reset: applied synchronously while rst=0 at a rising edge. State=IDLE, Mem_Req_Ready=1, Read_data_Valid=0, Read_data=0, wait counter=0. RAM contents are NOT reset.
- Any reset mid-transaction aborts it: a pending read response is dropped; a write already committed stays committed.
- Mem_Req_Ready is 1 only in IDLE. Read_data_Valid is 1 only in RESP.
- States:
  - IDLE: request accepted at an edge when (MemRead|MemWrite) & Mem_Req_Ready.
  - WAIT: counts down the programmed latency.
  - RESP: presents load data.
- Write accept at edge k:
  - RAM word updated at edge k, only for the lanes enabled in Write_strb.
  - Write_strb=4'b0000 is a legal no-op write.
  - LATENCY=0: stay in IDLE. Otherwise go to WAIT; Mem_Req_Ready=0 for exactly LATENCY cycles, then IDLE.
  - No response phase for writes.
- Read accept at edge k:
  - RAM word is captured into Read_data at edge k.
  - LATENCY=0: go to RESP, so Read_data_Valid=1 in cycle k+1. Otherwise go to WAIT; Read_data_Valid first high in cycle k+1+LATENCY.
- RESP: hold Read_data_Valid=1 and Read_data until Read_data_Ready=1 at an edge, then return to IDLE. Read_data keeps its last value afterwards.
- MemRead and MemWrite both 1 at accept: treated as a write only; no response.
- Request signals while Mem_Req_Ready=0 are ignored. The CPU must hold them until accepted.
- Read_data_Ready while not in RESP is ignored.
- Address wrap: index uses only ADDR_W bits, so address 4*2^ADDR_W aliases word 0.
- Wait counter is 4 bits; it reloads on every accept and never underflows (it leaves WAIT on reaching 1).

Optional Feature:
- Macro MEM_RAND_DELAY_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded with LFSR_SEED at reset, advances every cycle.
  - On each accept, the WAIT length is LATENCY + LFSR[1:0] (0..3 extra cycles), used to stress CPU stall handling.
  - The value is deterministic given the seed.
- Undefined: the LFSR is absent and the latency is exactly LATENCY.

Test Plan:
- Reset then idle, LATENCY=2: hold rst=0 two cycles, release → Mem_Req_Ready=1, Read_data_Valid=0, Read_data=0.
- Full write then read, LATENCY=2:
  - Write Address=0x10, data 0xDEADBEEF, strb 1111 → Mem_Req_Ready low 2 cycles.
  - Then read 0x10 → Read_data_Valid rises 3 cycles after the accept edge with 0xDEADBEEF.
- Byte strobes over existing 0xDEADBEEF at 0x10:
  - Write 0x11223344 with strb 0101 → readback 0xDE22BE44.
  - Write with strb 0000 → readback unchanged.
- Response backpressure: hold Read_data_Ready=0 for 5 cycles in RESP → Read_data_Valid and Read_data stable, Mem_Req_Ready=0. Raise it for 1 cycle → IDLE next cycle.
- Collision and wrap (ADDR_W=10):
  - MemRead=MemWrite=1 at 0x1000, data 0x5 → no Read_data_Valid.
  - Then read 0x0 → 0x00000005 (alias).
- Reset mid-RESP: assert rst=0 while Read_data_Valid=1 → next cycle Read_data_Valid=0, Mem_Req_Ready=1. A prior committed write is still readable.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder: byte-lane word RAM behind a request/response handshake with fixed access latency.
// Optional MEM_RAND_DELAY_EN adds 0..3 pseudo-random extra wait cycles from a 16-bit LFSR.
module data_mem_responder #(
    parameter int          ADDR_W    = 10,
    parameter int          LATENCY   = 2,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Address,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] Write_data,
    input  logic [3:0]  Write_strb,
    output logic        Mem_Req_Ready,
    output logic [31:0] Read_data,
    output logic        Read_data_Valid,
    input  logic        Read_data_Ready
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] LAT4 = LATENCY[3:0];

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        is_read_q, is_read_d;
    logic        ready_q, ready_d;
    logic        valid_q, valid_d;
    logic [3:0]  wait_len;
    logic [3:0][7:0] rd_bytes;

    logic [ADDR_W-1:0] idx;
    logic accept, wr_acc, rd_acc;

    assign idx    = Address[ADDR_W+1:2];
    assign accept = ready_q & (MemRead | MemWrite);
    assign wr_acc = accept & MemWrite;
    assign rd_acc = accept & MemRead & ~MemWrite;

`ifdef MEM_RAND_DELAY_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic [4:0]  wait_sum;
    logic        unused_addr;

    assign lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign wait_sum = {1'b0, LAT4} + {3'b000, lfsr_q[1:0]};
    // Saturate so the 4-bit counter cannot wrap when LATENCY is near its maximum.
    assign wait_len = wait_sum[4] ? 4'hF : wait_sum[3:0];
    assign unused_addr = ^{Address[1:0], Address[31:ADDR_W+2]};

    always_ff @(posedge clk) begin
        if (!rst) lfsr_q <= LFSR_SEED;
        else      lfsr_q <= lfsr_d;
    end
`else
    logic unused_addr;

    assign wait_len    = LAT4;
    assign unused_addr = ^{Address[1:0], Address[31:ADDR_W+2], LFSR_SEED};
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_read_d = is_read_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    is_read_d = rd_acc;
                    cnt_d     = wait_len;
                    if (wait_len != 4'd0) state_d = WAIT;
                    else if (rd_acc)      state_d = RESP;
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) state_d = is_read_q ? RESP : IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESP: begin
                if (Read_data_Ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            is_read_q <= 1'b0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_read_q <= is_read_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
        end
    end

    // One RAM per byte lane so strobed writes map onto plain block RAM.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] ram [0:DEPTH-1];
            logic [7:0] rd_q;

            always_ff @(posedge clk) begin
                if (wr_acc && Write_strb[gi]) ram[idx] <= Write_data[8*gi +: 8];
            end

            always_ff @(posedge clk) begin
                if (!rst)        rd_q <= 8'h00;
                else if (rd_acc) rd_q <= ram[idx];
            end

            assign rd_bytes[gi] = rd_q;
        end
    endgenerate

    assign Mem_Req_Ready   = ready_q;
    assign Read_data_Valid = valid_q;
    assign Read_data       = rd_bytes;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: reads push expected words, responses pop and compare.
module tb_data_mem_responder;

    localparam int ADDR_W = 10;
    localparam int LAT    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] Address = '0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [31:0] Write_data = '0;
    logic [3:0]  Write_strb = '0;
    logic        Mem_Req_Ready;
    logic [31:0] Read_data;
    logic        Read_data_Valid;
    logic        Read_data_Ready = 1'b0;

    int errors = 0;
    int checks = 0;
    logic [31:0] model [int];
    logic [31:0] sb_q [$];

    data_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .Address(Address), .MemWrite(MemWrite), .MemRead(MemRead),
        .Write_data(Write_data), .Write_strb(Write_strb), .Mem_Req_Ready(Mem_Req_Ready),
        .Read_data(Read_data), .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int word_idx(input logic [31:0] addr);
        return int'((addr >> 2) & ((32'd1 << ADDR_W) - 1));
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] w;
        int k;
        k = word_idx(addr);
        w = model.exists(k) ? model[k] : 32'h0;
        for (int b = 0; b < 4; b++)
            if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
        model[k] = w;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!Mem_Req_Ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_value("req_ready_wait", {31'd0, Mem_Req_Ready}, 32'd1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic also_read);
        wait_ready();
        Address = addr; Write_data = data; Write_strb = strb;
        MemWrite = 1'b1; MemRead = also_read;
        @(posedge clk);
        model_write(addr, data, strb);
        $display("WR addr=%h data=%h strb=%b rd=%0b", addr, data, strb, also_read);
        for (int i = 1; i <= LAT + 3; i++) begin
            @(negedge clk);
            if (i == 1) begin MemWrite = 1'b0; MemRead = 1'b0; end
            if (i <= LAT + 1)
                check_value("wr_ready", {31'd0, Mem_Req_Ready}, (i <= LAT) ? 32'd0 : 32'd1);
            if (also_read) check_value("collide_no_valid", {31'd0, Read_data_Valid}, 32'd0);
        end
    endtask

    // Issues a read and waits for the response; leaves the response pending so the caller can consume it.
    task automatic start_read(input logic [31:0] addr, output logic ok);
        int n = 0;
        int k;
        ok = 1'b0;
        wait_ready();
        Address = addr; MemRead = 1'b1; MemWrite = 1'b0;
        @(posedge clk);
        k = word_idx(addr);
        sb_q.push_back(model.exists(k) ? model[k] : 32'h0);
        do begin
            @(negedge clk);
            n++;
            if (n == 1) MemRead = 1'b0;
        end while (!Read_data_Valid && n < 40);
        if (!Read_data_Valid) begin
            check_value("rd_timeout", 32'd0, 32'd1);
            return;
        end
        ok = 1'b1;
        check_value("rd_latency", n, LAT + 1);
        check_value("resp_ready_low", {31'd0, Mem_Req_Ready}, 32'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, input int hold);
        logic ok;
        logic [31:0] exp;
        start_read(addr, ok);
        if (!ok) return;
        exp = sb_q.pop_front();
        check_value("rd_data", Read_data, exp);
        $display("RD addr=%h data=%h exp=%h hold=%0d", addr, Read_data, exp, hold);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_value("hold_valid", {31'd0, Read_data_Valid}, 32'd1);
            check_value("hold_data", Read_data, exp);
            check_value("hold_ready", {31'd0, Mem_Req_Ready}, 32'd0);
        end
        Read_data_Ready = 1'b1;
        @(negedge clk);
        Read_data_Ready = 1'b0;
        check_value("post_valid", {31'd0, Read_data_Valid}, 32'd0);
        check_value("post_ready", {31'd0, Mem_Req_Ready}, 32'd1);
        check_value("post_data_kept", Read_data, exp);
    endtask

    initial begin
        logic ok;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        check_value("rst_ready", {31'd0, Mem_Req_Ready}, 32'd1);
        check_value("rst_valid", {31'd0, Read_data_Valid}, 32'd0);
        check_value("rst_data", Read_data, 32'd0);
        $display("RST released");

        do_write(32'h10, 32'hDEADBEEF, 4'b1111, 1'b0);
        do_read(32'h10, 0);
        do_write(32'h11, 32'h11223344, 4'b0101, 1'b0);
        do_read(32'h10, 0);
        do_write(32'h10, 32'hFFFFFFFF, 4'b0000, 1'b0);
        do_read(32'h10, 5);

        do_write(32'h1000, 32'h5, 4'b1111, 1'b1);
        do_read(32'h0, 0);

        for (int t = 0; t < 4; t++)
            do_write(32'h200 + 32'(4 * t), $urandom, 4'($urandom_range(0, 15)), 1'b0);
        for (int t = 0; t < 4; t++)
            do_read(32'h200 + 32'(4 * t), t);

        start_read(32'h10, ok);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_value("midrst_valid", {31'd0, Read_data_Valid}, 32'd0);
        check_value("midrst_ready", {31'd0, Mem_Req_Ready}, 32'd1);
        check_value("midrst_data", Read_data, 32'd0);
        sb_q.delete();
        rst = 1'b1;
        $display("RST mid-response");
        do_read(32'h10, 0);
        do_read(32'h0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
